// File: rtl/mdu.sv
// mdu -- multiply/divide unit for the EX stage of the pipelined MIPS core.
//
// Performs mult/multu/div/divu into the HI/LO pair with a fixed latency and
// handles direct HI/LO writes (mthi/mtlo). The result is computed once at
// launch into a pending register and only committed to HI/LO on the edge
// where the run counter reaches zero, so HI/LO never show partial values.
//
// Ports
//   clk       in   1   clock, rising edge
//   reset     in   1   synchronous active-high; clears HI, LO, busy, counter
//   MDU_num1  in   32  operand A (rs): dividend/multiplicand, mthi/mtlo data
//   MDU_num2  in   32  operand B (rt): divisor/multiplier
//   start     in   1   one-cycle launch pulse for ops 1..4
//   MDUop     in   6   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo
//   busy      out  1   high while a mult/div is in flight
//   HI        out  32  architectural HI register
//   LO        out  32  architectural LO register
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] MDU_num1,
  input  logic [31:0] MDU_num2,
  input  logic        start,
  input  logic [5:0]  MDUop,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [5:0] OP_MULT  = 6'd1;
  localparam logic [5:0] OP_MULTU = 6'd2;
  localparam logic [5:0] OP_DIV   = 6'd3;
  localparam logic [5:0] OP_DIVU  = 6'd4;
  localparam logic [5:0] OP_MTHI  = 6'd5;
  localparam logic [5:0] OP_MTLO  = 6'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [63:0]        pend_q, pend_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;

  // Full {hi,lo} result of a mult/div. A zero divisor returns keep so the
  // commit at the end of the run leaves HI/LO as they were.
  function automatic logic [63:0] calc_result(input logic [5:0]  op,
                                              input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic [63:0] keep);
    logic signed [31:0] sa, sb, q, m;
    logic signed [63:0] pa, pb;
    logic [63:0]        r;
    sa = $signed(a);
    sb = $signed(b);
    pa = sa;
    pb = sb;
    q  = '0;
    m  = '0;
    r  = keep;
    case (op)
      OP_MULT:  r = pa * pb;
      OP_MULTU: r = {32'd0, a} * {32'd0, b};
      OP_DIV: begin
        if (b == 32'd0) begin
          r = keep;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          // Overflow case: quotient wraps to the dividend, remainder is zero.
          r = {32'd0, a};
        end else begin
          q = sa / sb;
          m = sa % sb;
          r = {m, q};
        end
      end
      OP_DIVU: begin
        if (b != 32'd0) r = {a % b, a / b};
      end
      default: r = keep;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start && (MDUop >= OP_MULT) && (MDUop <= OP_DIVU)) begin
          pend_d  = calc_result(MDUop, MDU_num1, MDU_num2, {hi_q, lo_q});
          cnt_d   = (MDUop <= OP_MULTU) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
          state_d = RUN;
        end else if (MDUop == OP_MTHI) begin
          hi_d = MDU_num1;
        end else if (MDUop == OP_MTLO) begin
          lo_d = MDU_num1;
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          hi_d    = pend_q[63:32];
          lo_d    = pend_q[31:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
module tb_mdu;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] MDU_num1, MDU_num2;
  logic        start;
  logic [5:0]  MDUop;
  logic        busy;
  logic [31:0] HI, LO;

  int tests_run = 0;
  int tests_failed = 0;

  // Architectural model of HI/LO.
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .MDU_num1(MDU_num1), .MDU_num2(MDU_num2),
    .start(start), .MDUop(MDUop), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference result from the instruction semantics using native integer types.
  function automatic logic [63:0] ref_calc(input logic [5:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint      sp;
    longint unsigned up;
    int          sa, sb;
    int unsigned ua, ub;
    sa = int'(a); sb = int'(b); ua = a; ub = b;
    case (op)
      6'd1: begin sp = longint'(sa) * longint'(sb); return 64'(sp); end
      6'd2: begin up = longint'(ua) * longint'(ub); return up; end
      6'd3: begin
        if (b == 0) return {m_hi, m_lo};
        if (a == 32'h8000_0000 && sb == -1) return {32'd0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 0) return {m_hi, m_lo};
        return {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
  endfunction

  // inj: 0 nothing, 1 second start mid-run, 2 mthi mid-run
  task automatic do_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int inj);
    int n, exp_n;
    logic [63:0] exp;
    exp   = ref_calc(op, a, b);
    exp_n = (op <= 6'd2) ? MULT_N : DIV_N;
    MDU_num1 = a; MDU_num2 = b; MDUop = op; start = 1'b1;
    @(negedge clk);
    start = 1'b0; MDUop = 6'd0;
    n = 0;
    while (busy && n < 40) begin
      check("hold", {HI, LO}, {m_hi, m_lo});
      n++;
      if (inj == 1 && n == 2) begin
        MDU_num1 = $urandom; MDU_num2 = $urandom; MDUop = 6'd3; start = 1'b1;
      end else if (inj == 2 && n == 2) begin
        MDU_num1 = 32'hDEAD_BEEF; MDUop = 6'd5;
      end else begin
        start = 1'b0; MDUop = 6'd0;
      end
      @(negedge clk);
    end
    check("busy_len", 64'(n), 64'(exp_n));
    {m_hi, m_lo} = exp;
    check("result", {HI, LO}, exp);
  endtask

  task automatic do_mt(input logic [5:0] op, input logic [31:0] a);
    MDU_num1 = a; MDUop = op;
    @(negedge clk);
    MDUop = 6'd0;
    if (op == 6'd5) m_hi = a; else m_lo = a;
    check("mt", {HI, LO}, {m_hi, m_lo});
  endtask

  initial begin
    logic [5:0]  op;
    logic [31:0] a, b;
    reset = 1'b1; start = 1'b0; MDUop = 6'd0; MDU_num1 = 32'd0; MDU_num2 = 32'd0;
    @(negedge clk); @(negedge clk);
    check("reset_hilo", {HI, LO}, 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    reset = 1'b0;

    do_op(6'd1, 32'hFFFF_FFFE, 32'h3, 0);
    check("mult_vec", {HI, LO}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
    do_op(6'd2, 32'hFFFF_FFFF, 32'h2, 0);
    check("multu_vec", {HI, LO}, {32'h1, 32'hFFFF_FFFE});
    do_op(6'd3, 32'hFFFF_FFF9, 32'h2, 0);
    check("div_vec", {HI, LO}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    do_op(6'd4, 32'd7, 32'd2, 1);
    check("divu_restart", {HI, LO}, {32'd1, 32'd3});
    do_mt(6'd5, 32'h1234);
    do_mt(6'd6, 32'h5678);
    check("mt_vec", {HI, LO}, {32'h1234, 32'h5678});
    do_op(6'd2, 32'd3, 32'd4, 2);
    check("mthi_busy", {HI, LO}, {32'd0, 32'd12});
    do_op(6'd3, 32'h1111_2222, 32'd0, 0);
    check("div0", {HI, LO}, {32'd0, 32'd12});
    do_op(6'd4, 32'h1111_2222, 32'd0, 0);
    do_op(6'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("div_ovf", {HI, LO}, {32'd0, 32'h8000_0000});

    // start with a non-launching opcode
    MDUop = 6'd7; start = 1'b1; MDU_num1 = 32'hAAAA_AAAA;
    @(negedge clk);
    start = 1'b0; MDUop = 6'd0;
    check("nop_busy", 64'(busy), 64'd0);
    check("nop_hilo", {HI, LO}, {m_hi, m_lo});

    // random mix
    for (int i = 0; i < 40; i++) begin
      op = 6'($urandom_range(1, 6));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
      if (op >= 6'd5) do_mt(op, a);
      else            do_op(op, a, b, 0);
    end

    // reset in cycle 3 of a mult
    MDU_num1 = 32'h7FFF_0001; MDU_num2 = 32'h0000_1234; MDUop = 6'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; MDUop = 6'd0;
    @(negedge clk); @(negedge clk);
    check("mid_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hilo", {HI, LO}, 64'd0);
    repeat (6) @(negedge clk);
    check("abort_never", {HI, LO}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
